// File: rtl/ascon_perm_iter.sv
// Iterative Ascon permutation: applies nr rounds of pL o pS o pC to a 320-bit state,
// UNROLL rounds per clock, with a start/ready/done handshake.

package ascon_pkg;
  // Word [0] is x0 ... word [4] is x4.
  typedef logic [4:0][63:0] type_state;
endpackage

module Pc
  import ascon_pkg::*;
(
  input  type_state  state_i,
  input  logic [3:0] rnd_i,
  output type_state  state_o
);
  logic [3:0] hi_nib;
  logic [7:0] rc;

  always_comb begin
    hi_nib  = 4'hF - rnd_i;
    rc      = {hi_nib, rnd_i};
    state_o = state_i;
    state_o[2][7:0] = state_i[2][7:0] ^ rc;
  end
endmodule

module Ps
  import ascon_pkg::*;
(
  input  type_state state_i,
  output type_state state_o
);
  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] t0, t1, t2, t3, t4;
  logic [63:0] b0, b1, b2, b3, b4;

  // Bit-sliced 5-bit S-box applied to all 64 columns at once.
  always_comb begin
    a0 = state_i[0] ^ state_i[4];
    a1 = state_i[1];
    a2 = state_i[2] ^ state_i[1];
    a3 = state_i[3];
    a4 = state_i[4] ^ state_i[3];
    t0 = ~a0 & a1;
    t1 = ~a1 & a2;
    t2 = ~a2 & a3;
    t3 = ~a3 & a4;
    t4 = ~a4 & a0;
    b0 = a0 ^ t1;
    b1 = a1 ^ t2;
    b2 = a2 ^ t3;
    b3 = a3 ^ t4;
    b4 = a4 ^ t0;
    state_o[0] = b0 ^ b4;
    state_o[1] = b1 ^ b0;
    state_o[2] = ~b2;
    state_o[3] = b3 ^ b2;
    state_o[4] = b4;
  end
endmodule

module Pl
  import ascon_pkg::*;
(
  input  type_state state_i,
  output type_state state_o
);
  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    logic [127:0] d;
    d = {x, x} >> n;
    return d[63:0];
  endfunction

  always_comb begin
    state_o[0] = state_i[0] ^ rotr(state_i[0], 19) ^ rotr(state_i[0], 28);
    state_o[1] = state_i[1] ^ rotr(state_i[1], 61) ^ rotr(state_i[1], 39);
    state_o[2] = state_i[2] ^ rotr(state_i[2], 1)  ^ rotr(state_i[2], 6);
    state_o[3] = state_i[3] ^ rotr(state_i[3], 10) ^ rotr(state_i[3], 17);
    state_o[4] = state_i[4] ^ rotr(state_i[4], 7)  ^ rotr(state_i[4], 41);
  end
endmodule

module ascon_perm_iter
  import ascon_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic [3:0] nr_i,
  input  type_state  state_i,
  output logic       ready_o,
  output logic       done_o,
  output type_state  state_o
);
  if (UNROLL < 1 || UNROLL > 4) begin : g_bad_unroll
    $error("ascon_perm_iter: UNROLL must be 1, 2, 3 or 4");
  end

  typedef enum logic [1:0] {IDLE, BUSY, DONE} fsm_t;

  fsm_t       fsm_q, fsm_d;
  type_state  state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic [3:0] nr_c;
  logic [4:0] rnd_sum;

  type_state  chain [UNROLL+1];

  assign chain[0] = state_q;

  // Stages past round 11 pass through, covering a final partial cycle.
  for (genvar gi = 0; gi < UNROLL; gi++) begin : g_stage
    logic [4:0] rnd_k;
    type_state  pc_out, ps_out, pl_out;

    assign rnd_k = {1'b0, rnd_q} + 5'(gi);

    Pc u_pc (.state_i(chain[gi]), .rnd_i(rnd_k[3:0]), .state_o(pc_out));
    Ps u_ps (.state_i(pc_out), .state_o(ps_out));
    Pl u_pl (.state_i(ps_out), .state_o(pl_out));

    assign chain[gi+1] = (rnd_k > 5'd11) ? chain[gi] : pl_out;
  end

  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    rnd_d   = rnd_q;
    nr_c    = (nr_i > 4'd12) ? 4'd12 : nr_i;
    rnd_sum = {1'b0, rnd_q} + 5'(UNROLL);
    case (fsm_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d = state_i;
          if (nr_c == 4'd0) begin
            fsm_d = DONE;
          end else begin
            rnd_d = 4'd12 - nr_c;
            fsm_d = BUSY;
          end
        end else begin
          fsm_d = IDLE;
        end
      end
      BUSY: begin
        state_d = chain[UNROLL];
        rnd_d   = rnd_sum[3:0];
        if (rnd_sum >= 5'd12) begin
          fsm_d = DONE;
        end
      end
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!resetb_i) begin
      fsm_q   <= IDLE;
      state_q <= '0;
      rnd_q   <= '0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      rnd_q   <= rnd_d;
    end
  end

  assign ready_o = (fsm_q != BUSY);
  assign done_o  = (fsm_q == DONE);
  assign state_o = state_q;
endmodule

// File: tb/tb_ascon_perm_iter.sv
// Scoreboard bench: four engines (UNROLL=1..4) share stimulus; each has its own
// expected-result queue filled on acceptance and drained by a monitor on done_o.
module tb_ascon_perm_iter;
  import ascon_pkg::*;

  logic       clk = 1'b0;
  logic       resetb;
  logic       start;
  logic [3:0] nr;
  type_state  st_in;
  logic [3:0] ready;
  logic [3:0] done;
  type_state  st_out [4];

  int        n_cmp = 0;
  int        n_bad = 0;
  int        cyc = 0;
  type_state tb_exp;
  type_state vec;
  int        done0_last = 0;
  int        done0_prev = 0;
  int        done0_cnt = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [63:0] rr(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic logic [4:0] sbox_lut(input logic [4:0] i);
    case (i)
      5'd0:  return 5'h04; 5'd1:  return 5'h0b; 5'd2:  return 5'h1f; 5'd3:  return 5'h14;
      5'd4:  return 5'h1a; 5'd5:  return 5'h15; 5'd6:  return 5'h09; 5'd7:  return 5'h02;
      5'd8:  return 5'h1b; 5'd9:  return 5'h05; 5'd10: return 5'h08; 5'd11: return 5'h12;
      5'd12: return 5'h1d; 5'd13: return 5'h03; 5'd14: return 5'h06; 5'd15: return 5'h1c;
      5'd16: return 5'h1e; 5'd17: return 5'h13; 5'd18: return 5'h07; 5'd19: return 5'h0e;
      5'd20: return 5'h00; 5'd21: return 5'h0d; 5'd22: return 5'h11; 5'd23: return 5'h18;
      5'd24: return 5'h10; 5'd25: return 5'h0c; 5'd26: return 5'h01; 5'd27: return 5'h19;
      5'd28: return 5'h16; 5'd29: return 5'h0a; 5'd30: return 5'h0f; default: return 5'h17;
    endcase
  endfunction

  function automatic type_state ref_round(input type_state s, input int r);
    type_state  t;
    logic [4:0] col, o;
    s[2][7:0] = s[2][7:0] ^ 8'((15 - r) * 16 + r);
    for (int b = 0; b < 64; b++) begin
      col = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
      o = sbox_lut(col);
      t[0][b] = o[4]; t[1][b] = o[3]; t[2][b] = o[2]; t[3][b] = o[1]; t[4][b] = o[0];
    end
    s[0] = t[0] ^ rr(t[0], 19) ^ rr(t[0], 28);
    s[1] = t[1] ^ rr(t[1], 61) ^ rr(t[1], 39);
    s[2] = t[2] ^ rr(t[2], 1)  ^ rr(t[2], 6);
    s[3] = t[3] ^ rr(t[3], 10) ^ rr(t[3], 17);
    s[4] = t[4] ^ rr(t[4], 7)  ^ rr(t[4], 41);
    return s;
  endfunction

  function automatic type_state ref_perm(input type_state s, input int n);
    for (int r = 12 - n; r < 12; r++) s = ref_round(s, r);
    return s;
  endfunction

  // ---------------- checking helpers ----------------
  task automatic chk_st(input string nm, input type_state act, input type_state exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h need %h", nm, act, exp);
    end
  endtask

  task automatic chk_v(input string nm, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d need %0d", nm, act, exp);
    end
  endtask

  // ---------------- DUTs, scoreboard push, monitors ----------------
  for (genvar gi = 0; gi < 4; gi++) begin : g_u
    type_state q_st[$];
    int        q_due[$];

    ascon_perm_iter #(.UNROLL(gi + 1)) u_dut (
      .clock_i (clk),
      .resetb_i(resetb),
      .start_i (start),
      .nr_i    (nr),
      .state_i (st_in),
      .ready_o (ready[gi]),
      .done_o  (done[gi]),
      .state_o (st_out[gi])
    );

    // Inputs are stable here, so this start is accepted on the next edge.
    always @(negedge clk) begin : push
      int nrc;
      if (resetb === 1'b1 && start === 1'b1 && ready[gi] === 1'b1) begin
        nrc = (nr > 4'd12) ? 12 : int'(nr);
        q_st.push_back(tb_exp);
        q_due.push_back(cyc + 1 + (nrc + gi) / (gi + 1));
      end
    end

    always @(negedge clk) begin : mon
      type_state e;
      int        due;
      if (done[gi] === 1'b1) begin
        if (q_st.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL u%0d unexpected_done: got done_o=1 at cycle %0d, need no pulse", gi + 1, cyc);
        end else begin
          e   = q_st.pop_front();
          due = q_due.pop_front();
          chk_st($sformatf("u%0d state_o", gi + 1), st_out[gi], e);
          chk_v($sformatf("u%0d done_cycle", gi + 1), cyc, due);
        end
      end
      if (resetb !== 1'b1) begin
        q_st.delete();
        q_due.delete();
      end
    end

    if (gi == 0) begin : g_spacing
      always @(negedge clk) begin
        if (done[0] === 1'b1) begin
          done0_prev = done0_last;
          done0_last = cyc;
          done0_cnt++;
        end
      end
    end
  end

  function automatic int pending();
    return g_u[0].q_st.size() + g_u[1].q_st.size() + g_u[2].q_st.size() + g_u[3].q_st.size();
  endfunction

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      chk_v($sformatf("%s u%0d ready_o", tag, i + 1), int'(ready[i]), 1);
      chk_v($sformatf("%s u%0d done_o", tag, i + 1), int'(done[i]), 0);
      chk_st($sformatf("%s u%0d state_o", tag, i + 1), st_out[i], '0);
    end
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (pending() == 0) begin
        @(negedge clk);
        return;
      end
    end
    n_cmp++;
    n_bad++;
    $display("FAIL wait_idle: got %0d results outstanding after %0d cycles, need 0", pending(), budget);
  endtask

  task automatic run_op(input type_state s, input logic [3:0] n, input type_state e,
                        input int busy_chk);
    @(posedge clk);
    #1;
    st_in  = s;
    nr     = n;
    tb_exp = e;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    st_in = ~s;
    for (int k = 0; k < busy_chk; k++) begin
      @(negedge clk);
      chk_v($sformatf("u1 ready_o busy cycle %0d", k + 1), int'(ready[0]), 0);
    end
    wait_idle(60);
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    type_state zero_s;
    type_state hand_r1;
    type_state alt;
    int        cnt0;

    vec[0] = 64'h00001000808C0001;
    vec[1] = 64'h6CB10AD9CA912F80;
    vec[2] = 64'h691AED630E81901F;
    vec[3] = 64'h0C4C36A20853217C;
    vec[4] = 64'h46487B3E06D9D7A8;
    zero_s = '0;
    // One round (c=0x4B) of the all-zero state, worked out by hand.
    hand_r1[0] = 64'h000964B00000004B;
    hand_r1[1] = 64'h0000000096000213;
    hand_r1[2] = 64'h53FFFFFFFFFFFF90;
    hand_r1[3] = 64'h12E580000000004B;
    hand_r1[4] = 64'h0000000000000000;
    alt = vec ^ {5{64'hA5A5_5A5A_F00F_0FF0}};

    // Reset held with start asserted: start must have no effect.
    resetb = 1'b0;
    start  = 1'b1;
    nr     = 4'd12;
    st_in  = vec;
    tb_exp = vec;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("in_reset");
    @(posedge clk);
    #1;
    resetb = 1'b1;
    start  = 1'b0;
    @(negedge clk);
    check_reset_state("after_reset");

    // p12 golden plus round-count sweep.
    run_op(vec, 4'd12, ref_perm(vec, 12), 12);
    run_op(vec, 4'd8,  ref_perm(vec, 8), 0);
    run_op(vec, 4'd6,  ref_perm(vec, 6), 0);
    run_op(vec, 4'd1,  ref_perm(vec, 1), 0);
    run_op(zero_s, 4'd1, hand_r1, 0);
    run_op(vec, 4'd0,  vec, 0);
    run_op(vec, 4'd15, ref_perm(vec, 12), 0);

    // Start pulse with a different state while every engine is busy.
    @(posedge clk);
    #1;
    st_in = vec; nr = 4'd12; tb_exp = ref_perm(vec, 12); start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    st_in = alt; nr = 4'd3; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(60);

    // Start held through DONE: back-to-back p6 operations.
    cnt0 = done0_cnt;
    @(posedge clk);
    #1;
    st_in = vec; nr = 4'd6; tb_exp = ref_perm(vec, 6); start = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(60);
    chk_v("u1 b2b done count", done0_cnt - cnt0, 2);
    chk_v("u1 b2b done spacing", done0_last - done0_prev, 7);

    // Reset in BUSY cycle 5 of a p12.
    @(posedge clk);
    #1;
    st_in = vec; nr = 4'd12; tb_exp = ref_perm(vec, 12); start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    resetb = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_state("mid_reset");
    @(posedge clk);
    #1;
    resetb = 1'b1;
    repeat (20) @(negedge clk);
    chk_v("outstanding results at end", pending(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
